mmu_map_loader: RTL and testbench
=================================

# mmu_map_loader

Bus-master sequencer that programs the rtf6829a memory mapper's page-map window over the CPU-side register bus, then writes its control register to enable translation. It sits beside the CPU on the mapper's register port: it requests the bus, issues byte writes while granted, and releases the bus when done. Entries come from an external synchronous table or are generated as a linear map from a base page.

## Interface
- `BASE_ADR`, 16'hF800: first byte address of the map window.
- `CTL_OFS`, 16'h0040: offset of the control register from `BASE_ADR`.
- `NUM_ENTRIES`, 32: map entries written; each entry is 2 bytes.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  one-cycle start pulse; ignored while `busy_o`.
- `linear_i`  in  1  sampled at start. 1 = entry i is `base_page_i + i`; 0 = entry i is read from the table.
- `base_page_i`  in  13  first physical page for linear mode; sampled at start.
- `ctl_val_i`  in  8  byte written to the control register; sampled at start.
- `tbl_adr_o`  out  5  table index, valid while `tbl_re_o`.
- `tbl_re_o`  out  1  table read strobe.
- `tbl_dat_i`  in  13  table data, valid the cycle after `tbl_re_o`.
- `bus_req_o`  out  1  bus request to the arbiter.
- `bus_gnt_i`  in  1  bus grant.
- `adr_o`  out  16  write address.
- `dat_o`  out  8  write data.
- `rw_n_o`  out  1  0 = write beat presented; 1 = idle.
- `busy_o`  out  1  sequence in progress.
- `done_o`  out  1  one-cycle pulse when the sequence completes.

## Operation
- States:
  - IDLE
  - FETCH: `tbl_re_o`=1, `tbl_adr_o`=idx.
  - WAIT: capture `tbl_dat_i` into the entry register.
  - WR_HI: `adr_o`=`BASE_ADR`+2·idx, `dat_o`={3'b0, entry[12:8]}.
  - WR_LO: `adr_o`=`BASE_ADR`+2·idx+1, `dat_o`=entry[7:0].
  - WR_CTL: `adr_o`=`BASE_ADR`+`CTL_OFS`, `dat_o`=ctl value.
  - DONE
- Transitions:
  - IDLE on `start_i`: table mode goes to FETCH with idx=0. Linear mode goes to WR_HI with entry=`base_page_i`.
  - FETCH → WAIT → WR_HI, unconditionally.
  - WR_HI → WR_LO only on an edge where `bus_gnt_i`=1; otherwise hold.
  - WR_LO on an edge with `bus_gnt_i`=1, when idx<`NUM_ENTRIES`-1: idx++, then go to FETCH (table mode) or to WR_HI with entry+1 (linear mode).
  - WR_LO on an edge with `bus_gnt_i`=1, at the last idx: go to WR_CTL.
  - WR_CTL → DONE on an edge with grant.
  - DONE → IDLE.
- Linear entry arithmetic is 13-bit modulo: 0x1FFF+1 = 0x0000.
- `bus_req_o`=1 in every non-IDLE, non-DONE state.
- `rw_n_o`=0 only in WR_HI, WR_LO and WR_CTL. A beat completes on a rising edge with `rw_n_o`=0 and `bus_gnt_i`=1.
- Grant may drop at any time. The current beat is held with address and data stable. No beat is skipped or duplicated.
- `start_i` during `busy_o` has no effect. `start_i` in the DONE cycle is also ignored.

## Timing
- Reset values: `bus_req_o`=0, `rw_n_o`=1, `adr_o`=0, `dat_o`=0, `tbl_re_o`=0, `tbl_adr_o`=0, `busy_o`=0, `done_o`=0. State is IDLE, idx=0.
- `rst` mid-sequence forces the reset values on the next edge. No partial beat completes after `rst` is sampled.
- Outputs are registered state decodes. `busy_o` rises the cycle after start is sampled, then `bus_req_o`, and (linear mode) the first write beat appear in that same cycle.
- Latency with grant held high, edge 0 = edge that samples `start_i`:
  - Table mode: 4 edges per entry. WR_CTL is presented after edge 4N; `done_o` is high after edge 4N+1; IDLE after edge 4N+2.
  - Linear mode: 2 edges per entry. `done_o` is high after edge 2N+1.
- Each cycle of grant loss adds exactly one cycle of latency to the held beat.
- Table read latency is exactly 1 cycle. Table data is never sampled outside WAIT.

## Structure
- Shared package `mmu_pkg` holds:
  - map-window constants: `MMU_MAP_BASE`=16'hF800, `MMU_CTL_OFS`=16'h0040.
  - `MMU_PAGE_BITS`=13.
  - the loader state enum.
- Single module; no sub-module is warranted. The table is external: a ROM or the register file owned by the integrator.

## Test plan
- Linear mode, base 0, `ctl_val_i`=0x00, grant held high:
  - writes F800=00, F801=00, F802=00, F803=01, …, F83E=00, F83F=1F, then F840=00.
  - `done_o` after edge 65.
- Linear mode, base 0x1FF0: entry 15 writes F81E=1F, F81F=FF; entry 16 wraps and writes F820=00, F821=00.
- Table mode, table[i]=0x1F00+i:
  - each F800+2i=1F and each F801+2i=i.
  - `tbl_re_o` asserted exactly 32 times.
  - `done_o` after edge 129.
- Grant toggled pseudo-randomly:
  - the write sequence is identical to the held-grant case.
  - `adr_o`/`dat_o` stay stable while `rw_n_o`=0 and grant is low.
- `rst` asserted during entry 10:
  - the next cycle shows `rw_n_o`=1, `bus_req_o`=0, `busy_o`=0.
  - a fresh start then completes all 32 entries from F800.
- `start_i` pulsed mid-sequence and in the DONE cycle: there is no restart and no extra writes; exactly one `done_o` pulse.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared definitions for the rtf6829a mapper loader: map-window layout,
// page width and loader sequencing states.
package mmu_pkg;

  localparam logic [15:0] MMU_MAP_BASE  = 16'hF800;
  localparam logic [15:0] MMU_CTL_OFS   = 16'h0040;
  localparam int unsigned MMU_PAGE_BITS = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WR_HI,
    S_WR_LO,
    S_WR_CTL,
    S_DONE
  } loader_state_e;

  // High byte of a map entry: page bits above 7, zero-extended.
  function automatic logic [7:0] page_hi(input logic [MMU_PAGE_BITS-1:0] page);
    logic [15:0] wide;
    wide = 16'(page);
    return wide[15:8];
  endfunction

  // Byte address of one half of map entry idx (lo=0 high byte, lo=1 low byte).
  function automatic logic [15:0] map_adr(input logic [15:0] base,
                                          input logic [4:0]  idx,
                                          input logic        lo);
    return base + {10'b0, idx, lo};
  endfunction

endpackage

// File: rtl/mmu_map_loader.sv
// Bus-master sequencer that fills the mapper's page-map window, entry by
// entry, then writes the control register to enable translation.
module mmu_map_loader
  import mmu_pkg::*;
#(
  parameter logic [15:0] BASE_ADR    = MMU_MAP_BASE,
  parameter logic [15:0] CTL_OFS     = MMU_CTL_OFS,
  parameter int unsigned NUM_ENTRIES = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     linear_i,
  input  logic [MMU_PAGE_BITS-1:0] base_page_i,
  input  logic [7:0]               ctl_val_i,
  output logic [4:0]               tbl_adr_o,
  output logic                     tbl_re_o,
  input  logic [MMU_PAGE_BITS-1:0] tbl_dat_i,
  output logic                     bus_req_o,
  input  logic                     bus_gnt_i,
  output logic [15:0]              adr_o,
  output logic [7:0]               dat_o,
  output logic                     rw_n_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_ENTRIES - 1);

  loader_state_e             state_q;
  logic [4:0]                idx_q;
  logic [MMU_PAGE_BITS-1:0]  entry_q;
  logic [7:0]                ctl_q;
  logic                      linear_q;
  logic [15:0]               adr_q;
  logic [7:0]                dat_q;
  logic                      rw_n_q;
  logic                      req_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      tbl_re_q;

  // Outputs are loaded together with the state they belong to, so every
  // output is a register and a held beat keeps address/data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      entry_q  <= '0;
      ctl_q    <= '0;
      linear_q <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      rw_n_q   <= 1'b1;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tbl_re_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            linear_q <= linear_i;
            ctl_q    <= ctl_val_i;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            req_q    <= 1'b1;
            if (linear_i) begin
              entry_q <= base_page_i;
              state_q <= S_WR_HI;
              rw_n_q  <= 1'b0;
              adr_q   <= map_adr(BASE_ADR, '0, 1'b0);
              dat_q   <= page_hi(base_page_i);
            end else begin
              state_q  <= S_FETCH;
              tbl_re_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          tbl_re_q <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          entry_q <= tbl_dat_i;
          state_q <= S_WR_HI;
          rw_n_q  <= 1'b0;
          adr_q   <= map_adr(BASE_ADR, idx_q, 1'b0);
          dat_q   <= page_hi(tbl_dat_i);
        end
        S_WR_HI: begin
          if (bus_gnt_i) begin
            state_q <= S_WR_LO;
            adr_q   <= map_adr(BASE_ADR, idx_q, 1'b1);
            dat_q   <= entry_q[7:0];
          end
        end
        S_WR_LO: begin
          if (bus_gnt_i) begin
            if (idx_q == LAST_IDX) begin
              state_q <= S_WR_CTL;
              adr_q   <= BASE_ADR + CTL_OFS;
              dat_q   <= ctl_q;
            end else if (linear_q) begin
              idx_q   <= idx_q + 5'd1;
              entry_q <= entry_q + 1'b1;
              state_q <= S_WR_HI;
              adr_q   <= map_adr(BASE_ADR, idx_q + 5'd1, 1'b0);
              dat_q   <= page_hi(entry_q + 1'b1);
            end else begin
              idx_q    <= idx_q + 5'd1;
              state_q  <= S_FETCH;
              tbl_re_q <= 1'b1;
              rw_n_q   <= 1'b1;
              adr_q    <= '0;
              dat_q    <= '0;
            end
          end
        end
        S_WR_CTL: begin
          if (bus_gnt_i) begin
            state_q <= S_DONE;
            idx_q   <= '0;
            rw_n_q  <= 1'b1;
            adr_q   <= '0;
            dat_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tbl_adr_o = idx_q;
  assign tbl_re_o  = tbl_re_q;
  assign bus_req_o = req_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign rw_n_o    = rw_n_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_mmu_map_loader.sv
// Self-checking bench for mmu_map_loader: write stream compared against a
// list computed from the map-window layout.
module tb_mmu_map_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        linear_i = 1'b0;
  logic [12:0] base_page_i = '0;
  logic [7:0]  ctl_val_i = '0;
  logic [4:0]  tbl_adr_o;
  logic        tbl_re_o;
  logic [12:0] tbl_dat_i;
  logic        bus_req_o;
  logic        bus_gnt_i = 1'b0;
  logic [15:0] adr_o;
  logic [7:0]  dat_o;
  logic        rw_n_o;
  logic        busy_o;
  logic        done_o;

  mmu_map_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .linear_i    (linear_i),
    .base_page_i (base_page_i),
    .ctl_val_i   (ctl_val_i),
    .tbl_adr_o   (tbl_adr_o),
    .tbl_re_o    (tbl_re_o),
    .tbl_dat_i   (tbl_dat_i),
    .bus_req_o   (bus_req_o),
    .bus_gnt_i   (bus_gnt_i),
    .adr_o       (adr_o),
    .dat_o       (dat_o),
    .rw_n_o      (rw_n_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  // Synchronous table: data for the index presented with the read strobe
  // appears after the next edge; otherwise the data lines carry X.
  logic [12:0] tbl [32];
  always @(posedge clk) tbl_dat_i <= tbl_re_o ? tbl[tbl_adr_o] : 13'bx;

  int n_asserts = 0;
  int n_fail    = 0;
  int tbl_reads = 0;
  logic [23:0] beats [$];
  logic [23:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: log the beat that this edge completes, then advance and
  // confirm a stalled beat kept its address and data.
  task automatic step();
    logic        held_valid;
    logic [23:0] held;
    held_valid = 1'b0;
    held       = '0;
    if (rw_n_o === 1'b0 && bus_gnt_i === 1'b1) beats.push_back({adr_o, dat_o});
    if (tbl_re_o === 1'b1) tbl_reads++;
    if (rw_n_o === 1'b0 && bus_gnt_i === 1'b0) begin
      held_valid = 1'b1;
      held       = {adr_o, dat_o};
    end
    @(posedge clk);
    #1;
    if (held_valid) begin
      check("held_beat", {7'b0, rw_n_o, adr_o, dat_o}, {8'b0, held});
    end
  endtask

  // Reference write list: 32 entries of two bytes each, then the control byte.
  task automatic build_exp(input bit lin, input int base, input int ctl);
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      int page;
      page = lin ? (base + i) % 8192 : int'(tbl[i]);
      exp_q.push_back({16'(32'hF800 + 2 * i),     8'(page / 256)});
      exp_q.push_back({16'(32'hF800 + 2 * i + 1), 8'(page % 256)});
    end
    exp_q.push_back({16'hF840, 8'(ctl)});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},  {31'b0, bus_req_o}, 32'd0);
    check({tag, "_rwn"},  {31'b0, rw_n_o},    32'd1);
    check({tag, "_busy"}, {31'b0, busy_o},    32'd0);
    check({tag, "_done"}, {31'b0, done_o},    32'd0);
    check({tag, "_re"},   {31'b0, tbl_re_o},  32'd0);
    check({tag, "_adr"},  {16'b0, adr_o},     32'd0);
  endtask

  task automatic run_seq(input string tag, input bit lin, input logic [12:0] base,
                         input logic [7:0] ctl, input bit rnd_gnt, input bit poke,
                         input int exp_done);
    int edges;
    int done_edge;
    int dones;
    bit fin;
    edges = 0;
    done_edge = -1;
    dones = 0;
    fin = 1'b0;
    build_exp(lin, int'(base), int'(ctl));
    beats.delete();
    tbl_reads = 0;
    linear_i    = lin;
    base_page_i = base;
    ctl_val_i   = ctl;
    bus_gnt_i   = 1'b1;
    start_i     = 1'b1;
    step();
    start_i     = 1'b0;
    linear_i    = ~lin;
    base_page_i = 13'($urandom);
    ctl_val_i   = 8'($urandom);
    while (!fin && edges < 2000) begin
      bus_gnt_i = rnd_gnt ? ($urandom_range(0, 2) != 0) : 1'b1;
      start_i   = poke && (edges == 20 || edges == done_edge);
      step();
      edges++;
      if (done_o === 1'b1) begin
        dones++;
        done_edge = edges;
      end
      if (done_edge >= 0 && edges >= done_edge + 4) fin = 1'b1;
    end
    start_i   = 1'b0;
    bus_gnt_i = 1'b1;
    check({tag, "_finished"}, {31'b0, fin}, 32'd1);
    check({tag, "_done_pulses"}, dones, 32'd1);
    if (exp_done >= 0) check({tag, "_done_edge"}, done_edge, exp_done);
    check({tag, "_tbl_reads"}, tbl_reads, lin ? 32'd0 : 32'd32);
    check_idle({tag, "_end"});
    check({tag, "_beat_count"}, beats.size(), 32'd65);
    for (int i = 0; i < 65 && i < beats.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), {8'b0, beats[i]}, {8'b0, exp_q[i]});
  endtask

  task automatic run_abort();
    int n;
    n = 0;
    linear_i    = 1'b1;
    base_page_i = 13'h0ABC;
    ctl_val_i   = 8'h5A;
    bus_gnt_i   = 1'b1;
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    while (n < 200 && !(rw_n_o === 1'b0 && adr_o === 16'hF814)) begin
      step();
      n++;
    end
    check("abort_reached_entry10", {31'b0, (n < 200)}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("abort_rst");
    step();
    check_idle("abort_after");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_dat", {24'b0, dat_o}, 32'd0);
    check("reset_tbl_adr", {27'b0, tbl_adr_o}, 32'd0);
    rst = 1'b0;
    step();

    run_seq("lin0", 1'b1, 13'h0000, 8'h00, 1'b0, 1'b0, 65);

    run_seq("linwrap", 1'b1, 13'h1FF0, 8'h81, 1'b0, 1'b0, 65);
    if (beats.size() >= 34) begin
      check("wrap_e15_hi", {8'b0, beats[30]}, 32'h00F81E1F);
      check("wrap_e15_lo", {8'b0, beats[31]}, 32'h00F81FFF);
      check("wrap_e16_hi", {8'b0, beats[32]}, 32'h00F82000);
      check("wrap_e16_lo", {8'b0, beats[33]}, 32'h00F82100);
    end else begin
      check("wrap_beats_present", beats.size(), 32'd34);
    end

    for (int i = 0; i < 32; i++) tbl[i] = 13'(32'h1F00 + i);
    run_seq("tbl", 1'b0, 13'h0000, 8'hC3, 1'b0, 1'b0, 129);

    for (int i = 0; i < 32; i++) tbl[i] = 13'($urandom);
    run_seq("tbl_rndgnt", 1'b0, 13'($urandom), 8'($urandom), 1'b1, 1'b0, -1);

    run_seq("lin_rndgnt", 1'b1, 13'($urandom), 8'($urandom), 1'b1, 1'b0, -1);

    run_abort();

    for (int i = 0; i < 32; i++) tbl[i] = 13'($urandom);
    run_seq("tbl_after_rst", 1'b0, 13'h0000, 8'h01, 1'b0, 1'b0, 129);

    run_seq("lin_poke", 1'b1, 13'($urandom), 8'($urandom), 1'b0, 1'b1, 65);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
